// File: rtl/op_fetch_pkg.sv
// ---------------------------------------------------------------------------
// op_fetch_pkg
// Shared definitions for the operand fetch stage that feeds the ALU:
//   - default widths (DEF_DATA_W, DEF_ADDR_W, DEF_REG_NUM) and REG_ZERO
//   - ALU control code constants driven on Control_ALU
//   - slot_t: the operand slot held between decode and the ALU
//   - src_hit(): "does this producer target this nonzero source" helper
// ---------------------------------------------------------------------------
package op_fetch_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_NUM = 32;
    localparam int DEF_ADDR_W  = 5;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SRL = 4'b1101;
    localparam logic [3:0] ALU_SLL = 4'b1111;

    // Operand slot. rs/rt/use_imm are kept so a stalled slot can pick up
    // late writeback (or forwarded) values for its sources.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] op1;
        logic [DEF_DATA_W-1:0] op2;
        logic [4:0]            shamt;
        logic [3:0]            ctrl;
        logic [DEF_ADDR_W-1:0] dest;
        logic [DEF_ADDR_W-1:0] rs;
        logic [DEF_ADDR_W-1:0] rt;
        logic                  use_imm;
    } slot_t;

    localparam slot_t SLOT_RESET = '{
        op1:     32'd0,
        op2:     32'd0,
        shamt:   5'd0,
        ctrl:    4'd0,
        dest:    5'd0,
        rs:      5'd0,
        rt:      5'd0,
        use_imm: 1'b0
    };

    // True when a producer (enable + destination) targets the given source.
    // Register 0 is never a valid producer target.
    function automatic logic src_hit(
        input logic                  en,
        input logic [DEF_ADDR_W-1:0] dst,
        input logic [DEF_ADDR_W-1:0] src
    );
        return en && (dst == src) && (dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
// Register file with two combinational read ports and one write port.
// Register 0 is hardwired to zero (writes to it are dropped). A read of the
// address being written in the same cycle returns the write data.
// Ports:
//   clock, reset            : clock, synchronous active-high reset (clears all)
//   we, waddr, wdata        : write port, applied at posedge
//   raddr_a/rdata_a         : read port A
//   raddr_b/rdata_b         : read port B
// ---------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    // Entry 0 has no storage; its reads are forced to zero below.
    logic [DATA_W-1:0] regs_r [1:REG_NUM-1];

    logic write_live_s;
    assign write_live_s = we && (waddr != {ADDR_W{1'b0}});

    // Storage update: clear on reset, otherwise apply a nonzero-address write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (write_live_s) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port A: zero register, then same-cycle write bypass, then storage.
    always_comb begin
        if (raddr_a == {ADDR_W{1'b0}}) begin
            rdata_a = {DATA_W{1'b0}};
        end else if (write_live_s && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = regs_r[raddr_a];
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        if (raddr_b == {ADDR_W{1'b0}}) begin
            rdata_b = {DATA_W{1'b0}};
        end else if (write_live_s && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = regs_r[raddr_b];
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
// Operand stage in front of the ALU: reads Rs/Rt from a 2R1W register file,
// selects the immediate when requested, and holds the result in one
// registered slot with a valid/ready handshake toward the ALU.
// Optional feature macro: OPFETCH_ALU_FWD_EN adds Fwd_Valid/Fwd_Dest/Fwd_Data,
// a forwarding path from the ALU result with priority over the register file
// (including its write bypass), both at capture and while a slot is stalled.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   In_Valid / In_Ready          : decode-side handshake
//   Rs, Rt, Imm, Use_Imm         : operand sources
//   Shamt_In, Ctrl_In, Dest_In   : passed through into the slot
//   Write_Enable/Addr/Data       : writeback into the register file
//   Flush                        : drop the held slot, block capture this cycle
//   Out_Valid / Out_Ready        : ALU-side handshake
//   Input_1, Input_2, Shamt,
//   Control_ALU, Out_Dest        : registered slot contents
// The slot type is sized by the package defaults, so DATA_W/ADDR_W/REG_NUM
// are expected to keep those default values.
// ---------------------------------------------------------------------------
module operand_fetch
    import op_fetch_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_NUM = DEF_REG_NUM,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    input  logic [DATA_W-1:0] Imm,
    input  logic              Use_Imm,
    input  logic [4:0]        Shamt_In,
    input  logic [3:0]        Ctrl_In,
    input  logic [ADDR_W-1:0] Dest_In,
    input  logic              Write_Enable,
    input  logic [ADDR_W-1:0] Write_Addr,
    input  logic [DATA_W-1:0] Write_Data,
`ifdef OPFETCH_ALU_FWD_EN
    input  logic              Fwd_Valid,
    input  logic [ADDR_W-1:0] Fwd_Dest,
    input  logic [DATA_W-1:0] Fwd_Data,
`endif
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Input_1,
    output logic [DATA_W-1:0] Input_2,
    output logic [4:0]        Shamt,
    output logic [3:0]        Control_ALU,
    output logic [ADDR_W-1:0] Out_Dest
);

    slot_t             slot_r;
    logic              out_valid_r;
    slot_t             capture_slot_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;
    logic [DATA_W-1:0] refresh_op1_s;
    logic [DATA_W-1:0] refresh_op2_s;
    logic              capture_s;
    logic              consume_s;

    regfile_2r1w #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we      (Write_Enable),
        .waddr   (Write_Addr),
        .wdata   (Write_Data),
        .raddr_a (Rs),
        .rdata_a (rd_a_s),
        .raddr_b (Rt),
        .rdata_b (rd_b_s)
    );

    // Flush takes the accept path away for its cycle so nothing sneaks in.
    assign In_Ready  = !Flush && (!out_valid_r || Out_Ready);
    assign capture_s = In_Valid && In_Ready;
    assign consume_s = out_valid_r && Out_Ready;

    // Build the slot that a capture would load (forward beats register file).
    always_comb begin
        capture_slot_s         = SLOT_RESET;
        capture_slot_s.shamt   = Shamt_In;
        capture_slot_s.ctrl    = Ctrl_In;
        capture_slot_s.dest    = Dest_In;
        capture_slot_s.rs      = Rs;
        capture_slot_s.rt      = Rt;
        capture_slot_s.use_imm = Use_Imm;
`ifdef OPFETCH_ALU_FWD_EN
        if (src_hit(Fwd_Valid, Fwd_Dest, Rs)) begin
            capture_slot_s.op1 = Fwd_Data;
        end else begin
            capture_slot_s.op1 = rd_a_s;
        end
        if (Use_Imm) begin
            capture_slot_s.op2 = Imm;
        end else if (src_hit(Fwd_Valid, Fwd_Dest, Rt)) begin
            capture_slot_s.op2 = Fwd_Data;
        end else begin
            capture_slot_s.op2 = rd_b_s;
        end
`else
        capture_slot_s.op1 = rd_a_s;
        if (Use_Imm) begin
            capture_slot_s.op2 = Imm;
        end else begin
            capture_slot_s.op2 = rd_b_s;
        end
`endif
    end

    // Late values for the held sources; an immediate operand is never refreshed.
    always_comb begin
        refresh_op1_s = slot_r.op1;
        refresh_op2_s = slot_r.op2;
`ifdef OPFETCH_ALU_FWD_EN
        if (src_hit(Fwd_Valid, Fwd_Dest, slot_r.rs)) begin
            refresh_op1_s = Fwd_Data;
        end else if (src_hit(Write_Enable, Write_Addr, slot_r.rs)) begin
            refresh_op1_s = Write_Data;
        end else begin
            refresh_op1_s = slot_r.op1;
        end
        if (slot_r.use_imm) begin
            refresh_op2_s = slot_r.op2;
        end else if (src_hit(Fwd_Valid, Fwd_Dest, slot_r.rt)) begin
            refresh_op2_s = Fwd_Data;
        end else if (src_hit(Write_Enable, Write_Addr, slot_r.rt)) begin
            refresh_op2_s = Write_Data;
        end else begin
            refresh_op2_s = slot_r.op2;
        end
`else
        if (src_hit(Write_Enable, Write_Addr, slot_r.rs)) begin
            refresh_op1_s = Write_Data;
        end else begin
            refresh_op1_s = slot_r.op1;
        end
        if (!slot_r.use_imm && src_hit(Write_Enable, Write_Addr, slot_r.rt)) begin
            refresh_op2_s = Write_Data;
        end else begin
            refresh_op2_s = slot_r.op2;
        end
`endif
    end

    // Slot register and valid flag: flush > capture > drain > stall refresh.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_r      <= SLOT_RESET;
            out_valid_r <= 1'b0;
        end else if (Flush) begin
            out_valid_r <= 1'b0;
        end else if (capture_s) begin
            slot_r      <= capture_slot_s;
            out_valid_r <= 1'b1;
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
        end else if (out_valid_r) begin
            slot_r.op1 <= refresh_op1_s;
            slot_r.op2 <= refresh_op2_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign Out_Valid   = out_valid_r;
    assign Input_1     = slot_r.op1;
    assign Input_2     = slot_r.op2;
    assign Shamt       = slot_r.shamt;
    assign Control_ALU = slot_r.ctrl;
    assign Out_Dest    = slot_r.dest;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
// Directed bench for operand_fetch: reset, register file write/bypass,
// capture, stall refresh, streaming, flush, reset during stall and (with
// OPFETCH_ALU_FWD_EN) forwarding priority.
// ---------------------------------------------------------------------------
module tb_operand_fetch;
    import op_fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        In_Valid;
    logic        In_Ready;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [31:0] Imm;
    logic        Use_Imm;
    logic [4:0]  Shamt_In;
    logic [3:0]  Ctrl_In;
    logic [4:0]  Dest_In;
    logic        Write_Enable;
    logic [4:0]  Write_Addr;
    logic [31:0] Write_Data;
`ifdef OPFETCH_ALU_FWD_EN
    logic        Fwd_Valid;
    logic [4:0]  Fwd_Dest;
    logic [31:0] Fwd_Data;
`endif
    logic        Flush;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Input_1;
    logic [31:0] Input_2;
    logic [4:0]  Shamt;
    logic [3:0]  Control_ALU;
    logic [4:0]  Out_Dest;

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .Rs           (Rs),
        .Rt           (Rt),
        .Imm          (Imm),
        .Use_Imm      (Use_Imm),
        .Shamt_In     (Shamt_In),
        .Ctrl_In      (Ctrl_In),
        .Dest_In      (Dest_In),
        .Write_Enable (Write_Enable),
        .Write_Addr   (Write_Addr),
        .Write_Data   (Write_Data),
`ifdef OPFETCH_ALU_FWD_EN
        .Fwd_Valid    (Fwd_Valid),
        .Fwd_Dest     (Fwd_Dest),
        .Fwd_Data     (Fwd_Data),
`endif
        .Flush        (Flush),
        .Out_Valid    (Out_Valid),
        .Out_Ready    (Out_Ready),
        .Input_1      (Input_1),
        .Input_2      (Input_2),
        .Shamt        (Shamt),
        .Control_ALU  (Control_ALU),
        .Out_Dest     (Out_Dest)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; In_Valid = 1'b0; Rs = 5'd0; Rt = 5'd0; Imm = 32'd0;
        Use_Imm = 1'b0; Shamt_In = 5'd0; Ctrl_In = 4'd0; Dest_In = 5'd0;
        Write_Enable = 1'b0; Write_Addr = 5'd0; Write_Data = 32'd0;
        Flush = 1'b0; Out_Ready = 1'b1;
`ifdef OPFETCH_ALU_FWD_EN
        Fwd_Valid = 1'b0; Fwd_Dest = 5'd0; Fwd_Data = 32'd0;
`endif

        // 1. reset held two cycles
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, Out_Valid}, 32'd0);
        check("rst_in1", Input_1, 32'd0);
        check("rst_in2", Input_2, 32'd0);
        check("rst_ready", {31'd0, In_Ready}, 32'd1);
        check("rst_shamt", {27'd0, Shamt}, 32'd0);
        check("rst_ctrl", {28'd0, Control_ALU}, 32'd0);
        check("rst_dest", {27'd0, Out_Dest}, 32'd0);
        In_Valid = 1'b1; Rs = 5'd5; Rt = 5'd5;
        tick();
        check("r5_valid", {31'd0, Out_Valid}, 32'd1);
        check("r5_in1", Input_1, 32'd0);
        check("r5_in2", Input_2, 32'd0);

        // 2. write r3, then capture Rs=3, Rt=0
        In_Valid = 1'b0; Write_Enable = 1'b1; Write_Addr = 5'd3; Write_Data = 32'h0000_00AA;
        tick();
        check("drain_valid", {31'd0, Out_Valid}, 32'd0);
        Write_Enable = 1'b0; In_Valid = 1'b1; Rs = 5'd3; Rt = 5'd0;
        Shamt_In = 5'd7; Ctrl_In = ALU_ADD; Dest_In = 5'd9;
        tick();
        check("cap_valid", {31'd0, Out_Valid}, 32'd1);
        check("cap_in1", Input_1, 32'h0000_00AA);
        check("cap_in2", Input_2, 32'd0);
        check("cap_shamt", {27'd0, Shamt}, 32'd7);
        check("cap_ctrl", {28'd0, Control_ALU}, 32'd2);
        check("cap_dest", {27'd0, Out_Dest}, 32'd9);

        // 3. write bypass in the capture cycle, then write to r0
        Rs = 5'd7; Rt = 5'd3; Write_Enable = 1'b1; Write_Addr = 5'd7; Write_Data = 32'h0000_1234;
        tick();
        check("byp_in1", Input_1, 32'h0000_1234);
        check("byp_in2", Input_2, 32'h0000_00AA);
        check("b2b_valid", {31'd0, Out_Valid}, 32'd1);
        Rs = 5'd0; Write_Addr = 5'd0; Write_Data = 32'hFFFF_FFFF;
        tick();
        check("r0_byp_in1", Input_1, 32'd0);
        Write_Enable = 1'b0; Rs = 5'd7; Rt = 5'd0;
        tick();
        check("r7_stored", Input_1, 32'h0000_1234);
        check("r0_ignored", Input_2, 32'd0);

        // 4. stall refresh
        Rs = 5'd3; Rt = 5'd4; Use_Imm = 1'b0;
        tick();
        check("stall_cap_in2", Input_2, 32'd0);
        In_Valid = 1'b0; Out_Ready = 1'b0;
        Write_Enable = 1'b1; Write_Addr = 5'd4; Write_Data = 32'hDEAD_BEEF;
        #1;
        check("stall_ready", {31'd0, In_Ready}, 32'd0);
        tick();
        check("refresh_in2", Input_2, 32'hDEAD_BEEF);
        check("refresh_in1_hold", Input_1, 32'h0000_00AA);
        check("refresh_valid", {31'd0, Out_Valid}, 32'd1);
        Write_Addr = 5'd3; Write_Data = 32'h0000_0033;
        tick();
        check("refresh_in1", Input_1, 32'h0000_0033);
        check("refresh_in2_hold", Input_2, 32'hDEAD_BEEF);
        Write_Enable = 1'b0; Out_Ready = 1'b1; In_Valid = 1'b1;
        Rs = 5'd4; Rt = 5'd4; Use_Imm = 1'b1; Imm = 32'h0000_5A5A;
        tick();
        check("imm_in1", Input_1, 32'hDEAD_BEEF);
        check("imm_in2", Input_2, 32'h0000_5A5A);
        In_Valid = 1'b0; Out_Ready = 1'b0;
        Write_Enable = 1'b1; Write_Addr = 5'd4; Write_Data = 32'h0000_0077;
        tick();
        check("imm_keep_in2", Input_2, 32'h0000_5A5A);
        check("imm_refresh_in1", Input_1, 32'h0000_0077);
        Write_Enable = 1'b0; Use_Imm = 1'b0;

        // 5. streaming, stall on slot 2, drain
        Out_Ready = 1'b1; In_Valid = 1'b1; Rs = 5'd3;
        tick();
        check("s1_valid", {31'd0, Out_Valid}, 32'd1);
        check("s1_in1", Input_1, 32'h0000_0033);
        Rs = 5'd4;
        tick();
        check("s2_valid", {31'd0, Out_Valid}, 32'd1);
        check("s2_in1", Input_1, 32'h0000_0077);
        Out_Ready = 1'b0; Rs = 5'd7;
        #1;
        check("s2_stall_ready", {31'd0, In_Ready}, 32'd0);
        tick();
        check("s2_hold_in1", Input_1, 32'h0000_0077);
        check("s2_hold_ready", {31'd0, In_Ready}, 32'd0);
        Out_Ready = 1'b1;
        #1;
        check("s2_release_ready", {31'd0, In_Ready}, 32'd1);
        tick();
        check("s3_valid", {31'd0, Out_Valid}, 32'd1);
        check("s3_in1", Input_1, 32'h0000_1234);
        In_Valid = 1'b0;
        tick();
        check("drain2_valid", {31'd0, Out_Valid}, 32'd0);
        check("drain2_in1", Input_1, 32'h0000_1234);

        // flush with an incoming slot; the write still lands
        In_Valid = 1'b1; Rs = 5'd3;
        tick();
        check("pre_flush_in1", Input_1, 32'h0000_0033);
        Flush = 1'b1; Rs = 5'd4; Out_Ready = 1'b0;
        Write_Enable = 1'b1; Write_Addr = 5'd5; Write_Data = 32'h0000_0099;
        #1;
        check("flush_ready", {31'd0, In_Ready}, 32'd0);
        tick();
        check("flush_valid", {31'd0, Out_Valid}, 32'd0);
        check("flush_drop_in1", Input_1, 32'h0000_0033);
        Flush = 1'b0; Write_Enable = 1'b0; Rs = 5'd5; Out_Ready = 1'b1;
        tick();
        check("flush_write_kept", Input_1, 32'h0000_0099);

        // flush beats refresh
        Rs = 5'd6;
        tick();
        check("r6_in1", Input_1, 32'd0);
        In_Valid = 1'b0; Out_Ready = 1'b0;
        tick();
        Flush = 1'b1; Write_Enable = 1'b1; Write_Addr = 5'd6; Write_Data = 32'h0000_0066;
        tick();
        check("flush_ref_valid", {31'd0, Out_Valid}, 32'd0);
        check("flush_ref_in1", Input_1, 32'd0);
        Flush = 1'b0; Write_Enable = 1'b0;

        // reset in the middle of a stall
        In_Valid = 1'b1; Rs = 5'd6; Out_Ready = 1'b1;
        tick();
        check("r6_written", Input_1, 32'h0000_0066);
        In_Valid = 1'b0; Out_Ready = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", {31'd0, Out_Valid}, 32'd0);
        check("mid_rst_in1", Input_1, 32'd0);
        check("mid_rst_dest", {27'd0, Out_Dest}, 32'd0);
        In_Valid = 1'b1; Rs = 5'd3; Out_Ready = 1'b1;
        tick();
        check("mid_rst_r3", Input_1, 32'd0);
        In_Valid = 1'b0;

`ifdef OPFETCH_ALU_FWD_EN
        // 6. forward beats write bypass, at capture and at refresh
        Fwd_Valid = 1'b1; Fwd_Dest = 5'd3; Fwd_Data = 32'h0000_0055;
        Write_Enable = 1'b1; Write_Addr = 5'd3; Write_Data = 32'h0000_0066;
        In_Valid = 1'b1; Rs = 5'd3; Rt = 5'd3; Use_Imm = 1'b0;
        tick();
        check("fwd_in1", Input_1, 32'h0000_0055);
        check("fwd_in2", Input_2, 32'h0000_0055);
        In_Valid = 1'b0; Out_Ready = 1'b0;
        Fwd_Data = 32'h0000_0011; Write_Data = 32'h0000_0022;
        tick();
        check("fwd_ref_in1", Input_1, 32'h0000_0011);
        Fwd_Valid = 1'b0; Write_Enable = 1'b0; Out_Ready = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
